dcache_assoc_controller: RTL and testbench

DCACHE_ASSOC_CONTROLLER -- requirements
Module: dcache_assoc_controller

---
 rtl/dcache_assoc_controller.sv | 204 ++++++++++++++++++++
 tb/tb_dcache_assoc_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc_controller.sv
// Two-way set-associative, write-back, write-allocate data cache controller with LRU replacement.
// Defining DCACHE_PERF_CNT_EN adds the hit_cnt_o / miss_cnt_o performance counters.
module dcache_assoc_controller #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       cpu_data_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    output logic              cpu_stall_o
);

    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int unsigned WORD_W = OFF_W - 2;
    localparam int unsigned LSEL_W = $clog2(LINE_W);
    localparam int unsigned SETS   = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t                   state_q;
    logic [1:0][SETS-1:0]     valid_q;
    logic [1:0][SETS-1:0]     dirty_q;
    logic [SETS-1:0]          lru_q;
    logic [TAG_W-1:0]         tag_q  [2][SETS];
    logic [LINE_W-1:0]        data_q [2][SETS];

    logic                     victim_q;
    logic [TAG_W-1:0]         miss_tag_q;
    logic [INDEX_W-1:0]       miss_idx_q;

    logic [TAG_W-1:0]         req_tag_c;
    logic [INDEX_W-1:0]       req_idx_c;
    logic [WORD_W-1:0]        req_word_c;
    logic [LSEL_W-1:0]        word_lsb_c;
    logic                     req_c;
    logic [1:0]               way_hit_c;
    logic                     hit_c;
    logic                     hit_way_c;
    logic                     miss_c;
    logic                     access_c;
    logic                     victim_c;
    logic                     fill_c;
    logic                     victim_dirty_c;
    logic                     unused_addr_c;

    // Address decode; the byte-within-word bits carry no meaning for 32-bit accesses.
    assign req_tag_c     = cpu_addr_i[ADDR_W-1:INDEX_W+OFF_W];
    assign req_idx_c     = cpu_addr_i[INDEX_W+OFF_W-1:OFF_W];
    assign req_word_c    = cpu_addr_i[OFF_W-1:2];
    assign word_lsb_c    = {req_word_c, 5'd0};
    assign unused_addr_c = ^cpu_addr_i[1:0];

    assign req_c        = cpu_MemRead_i | cpu_MemWrite_i;
    assign way_hit_c[0] = valid_q[0][req_idx_c] & (tag_q[0][req_idx_c] == req_tag_c);
    assign way_hit_c[1] = valid_q[1][req_idx_c] & (tag_q[1][req_idx_c] == req_tag_c);
    assign hit_c        = |way_hit_c;
    assign hit_way_c    = way_hit_c[1];
    assign miss_c       = req_c & ~hit_c;
    assign cpu_stall_o  = miss_c;

    // An access completes only while no fill is in flight for the set.
    assign access_c = req_c & hit_c & ((state_q == IDLE) | (state_q == READMISSOK));
    assign fill_c   = (state_q == READMISS) & mem_ack_i;

    always_comb begin
        cpu_data_o = 32'h0;
        if (way_hit_c[0]) begin
            cpu_data_o = data_q[0][req_idx_c][word_lsb_c +: 32];
        end else if (way_hit_c[1]) begin
            cpu_data_o = data_q[1][req_idx_c][word_lsb_c +: 32];
        end
    end

    // Victim choice: an empty way first (way 0 preferred), otherwise the LRU way.
    always_comb begin
        victim_c = lru_q[req_idx_c];
        if (!valid_q[0][req_idx_c]) begin
            victim_c = 1'b0;
        end else if (!valid_q[1][req_idx_c]) begin
            victim_c = 1'b1;
        end
    end

    assign victim_dirty_c = valid_q[victim_q][miss_idx_q] & dirty_q[victim_q][miss_idx_q];

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (fill_c) begin
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
            data_q[victim_q][miss_idx_q] <= mem_data_i;
        end else if (access_c && cpu_MemWrite_i) begin
            data_q[hit_way_c][req_idx_c][word_lsb_c +: 32] <= cpu_data_i;
        end
    end

    // Miss sequencer plus valid/dirty/LRU bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            lru_q        <= '0;
            victim_q     <= 1'b0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            if (access_c) begin
                lru_q[req_idx_c] <= ~hit_way_c;
                if (cpu_MemWrite_i) begin
                    dirty_q[hit_way_c][req_idx_c] <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (miss_c) begin
                        state_q    <= MISS;
                        victim_q   <= victim_c;
                        miss_tag_q <= req_tag_c;
                        miss_idx_q <= req_idx_c;
                    end
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_dirty_c) begin
                        state_q     <= WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {tag_q[victim_q][miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
                        mem_data_o  <= data_q[victim_q][miss_idx_q];
                    end else begin
                        state_q     <= READMISS;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= READMISS;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        state_q                       <= READMISSOK;
                        mem_enable_o                  <= 1'b0;
                        valid_q[victim_q][miss_idx_q] <= 1'b1;
                        dirty_q[victim_q][miss_idx_q] <= 1'b0;
                    end
                end
                READMISSOK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Hits count only accesses served directly from IDLE; misses count sequence starts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == IDLE) begin
            if (access_c) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (miss_c) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_assoc_controller.sv
// Scoreboard bench for dcache_assoc_controller: a line-level cache/memory model predicts
// memory transfers and load data; separate monitors compare what the DUT presents.
module tb_dcache_assoc_controller;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INDEX_W = 4;
    localparam int unsigned LINE_W  = 256;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [255:0] data;
    } mem_txn_t;

    logic              clk_i;
    logic              rst_i;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       cpu_data_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic              cpu_MemRead_i;
    logic              cpu_MemWrite_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;
`endif

    dcache_assoc_controller #(
        .ADDR_W (ADDR_W),
        .INDEX_W(INDEX_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .cpu_data_i    (cpu_data_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_MemRead_i (cpu_MemRead_i),
        .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o    (cpu_data_o),
`ifdef DCACHE_PERF_CNT_EN
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o),
`endif
        .cpu_stall_o   (cpu_stall_o)
    );

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    bit           hold_ack = 1'b0;

    mem_txn_t     exp_mem_q[$];
    logic [31:0]  exp_rd_q[$];

    // Reference model: cache contents per set/way plus the backing memory it implies.
    bit           m_v   [16][2];
    bit           m_d   [16][2];
    int unsigned  m_tag [16][2];
    logic [255:0] m_line[16][2];
    bit           m_lru [16];
    int unsigned  m_hits;
    int unsigned  m_misses;
    logic [255:0] model_mem[logic [31:0]];
    logic [255:0] phys_mem[logic [31:0]];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic finish_sim();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = la ^ (32'h9E3779B9 * 32'(k + 1));
        if (la == 32'h40) l[95:64] = 32'hDEADBEEF;
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_v[s][w] = 1'b0;
                m_d[s][w] = 1'b0;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Predicts the whole effect of one CPU access and queues the expected responses.
    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                output bit was_hit);
        int unsigned idx, tag, word;
        int          w;
        logic [31:0] la, va;
        mem_txn_t    t;
        idx  = (a >> 5) & 32'hF;
        tag  = a >> 9;
        word = (a >> 2) & 32'h7;
        la   = a & ~32'h1F;
        w    = -1;
        for (int i = 0; i < 2; i++) if (m_v[idx][i] && m_tag[idx][i] == tag) w = i;
        was_hit = (w >= 0);
        if (!was_hit) begin
            m_misses++;
            if (!m_v[idx][0]) w = 0;
            else if (!m_v[idx][1]) w = 1;
            else w = m_lru[idx] ? 1 : 0;
            if (m_v[idx][w] && m_d[idx][w]) begin
                va = (m_tag[idx][w] << 9) | (idx << 5);
                model_mem[va] = m_line[idx][w];
                t.wr = 1'b1; t.addr = va; t.data = m_line[idx][w];
                exp_mem_q.push_back(t);
            end
            t.wr = 1'b0; t.addr = la; t.data = '0;
            exp_mem_q.push_back(t);
            m_line[idx][w] = model_mem.exists(la) ? model_mem[la] : init_line(la);
            m_v[idx][w]    = 1'b1;
            m_d[idx][w]    = 1'b0;
            m_tag[idx][w]  = tag;
        end else begin
            m_hits++;
        end
        if (wr) begin
            m_line[idx][w][word*32 +: 32] = wd;
            m_d[idx][w] = 1'b1;
        end else begin
            exp_rd_q.push_back(m_line[idx][w][word*32 +: 32]);
        end
        m_lru[idx] = (w == 0);
    endtask

    // Issue one access and hold it until the DUT stops stalling.
    task automatic do_access(input logic [31:0] a, input bit wr, input logic [31:0] wd);
        bit exp_hit;
        int cyc;
        model_access(a, wr, wd, exp_hit);
        cpu_addr_i     = a;
        cpu_data_i     = wd;
        cpu_MemRead_i  = !wr;
        cpu_MemWrite_i = wr;
        @(negedge clk_i);
        chk("first_cycle_stall", cpu_stall_o, !exp_hit);
        cyc = 0;
        while (cpu_stall_o && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        if (cpu_stall_o) begin
            n_checks++;
            $display("FAIL access_timeout: addr %0h still stalled after %0d cycles, required completion", a, cyc);
            finish_sim();
        end
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    // CPU-side monitor: loads are compared against the model's queued words.
    initial begin : cpu_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && (cpu_MemRead_i || cpu_MemWrite_i)) begin
                if (cpu_stall_o) begin
                    chk("stall_data_zero", cpu_data_o, 32'h0);
                end else if (cpu_MemRead_i) begin
                    if (exp_rd_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL read_unexpected: got %0h with no load expected", cpu_data_o);
                    end else begin
                        e = exp_rd_q.pop_front();
                        chk("read_data", cpu_data_o, e);
                    end
                end
            end
        end
    end

    // Memory responder and memory-side monitor.
    initial begin : mem_responder
        mem_txn_t    e;
        bit          seen;
        int unsigned wait_cnt;
        logic [31:0] seen_addr;
        logic        seen_wr;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        seen       = 1'b0;
        wait_cnt   = 0;
        seen_addr  = '0;
        seen_wr    = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i || mem_ack_i) begin
                mem_ack_i = 1'b0;
                seen      = 1'b0;
            end else if (mem_enable_o) begin
                if (!seen) begin
                    seen      = 1'b1;
                    seen_addr = mem_addr_o;
                    seen_wr   = mem_write_o;
                    wait_cnt  = $urandom_range(0, 3);
                    if (exp_mem_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mem_unexpected: got wr=%0b addr=%0h with no transfer expected",
                                 mem_write_o, mem_addr_o);
                    end else begin
                        e = exp_mem_q.pop_front();
                        chk("mem_write", mem_write_o, e.wr);
                        chk("mem_addr", mem_addr_o, e.addr);
                        if (e.wr) chk("mem_wb_data", mem_data_o, e.data);
                    end
                end else begin
                    chk("mem_hold_addr", mem_addr_o, seen_addr);
                    chk("mem_hold_write", mem_write_o, seen_wr);
                end
                if (!hold_ack) begin
                    if (wait_cnt == 0) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) phys_mem[mem_addr_o] = mem_data_o;
                        else mem_data_i = phys_mem.exists(mem_addr_o) ? phys_mem[mem_addr_o]
                                                                      : init_line(mem_addr_o);
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        finish_sim();
    end

    initial begin : stimulus
        logic [31:0] a;
        int unsigned tag;
        int          cyc;
        rst_i          = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_enable", mem_enable_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Directed: cold miss, hits, clean eviction, dirty evictions.
        do_access(32'h0000_0040, 1'b0, 32'h0);
        do_access(32'h0000_0048, 1'b0, 32'h0);
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt_directed", hit_cnt_o, 32'd1);
        chk("miss_cnt_directed", miss_cnt_o, 32'd1);
`endif
        do_access(32'h0000_0044, 1'b1, 32'h1234_5678);
        do_access(32'h0000_0240, 1'b0, 32'h0);
        do_access(32'h0000_0040, 1'b0, 32'h0);
        do_access(32'h0000_0440, 1'b0, 32'h0);
        do_access(32'h0000_0248, 1'b1, 32'hCAFE_F00D);
        do_access(32'h0000_0040, 1'b0, 32'h0);
        do_access(32'h0000_0440, 1'b0, 32'h0);

        // Reset while the line fill is outstanding.
        hold_ack = 1'b1;
        begin
            bit dummy;
            model_access(32'h0000_0640, 1'b0, 32'h0, dummy);
        end
        cpu_addr_i    = 32'h0000_0640;
        cpu_MemRead_i = 1'b1;
        cyc = 0;
        while (!(mem_enable_o && !mem_write_o) && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("reach_readmiss", mem_enable_o && !mem_write_o, 1'b1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midmiss_rst_enable", mem_enable_o, 1'b0);
        chk("midmiss_rst_write", mem_write_o, 1'b0);
        chk("midmiss_rst_addr", mem_addr_o, 32'h0);
        cpu_MemRead_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        model_reset();
        exp_mem_q.delete();
        exp_rd_q.delete();
        hold_ack = 1'b0;
        rst_i    = 1'b0;
        @(posedge clk_i);
        #1;
        do_access(32'h0000_0440, 1'b0, 32'h0);

        // Randomized traffic over a few sets and conflicting tags.
        for (int n = 0; n < 300; n++) begin
            tag = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) tag = tag | 32'h0040_0000;
            a = (tag << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2)
                | $urandom_range(0, 3);
            do_access(a, ($urandom_range(0, 1) == 1), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #1;
            end
        end

        repeat (4) @(posedge clk_i);
        chk("mem_queue_drained", exp_mem_q.size(), 0);
        chk("read_queue_drained", exp_rd_q.size(), 0);
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt_final", hit_cnt_o, m_hits);
        chk("miss_cnt_final", miss_cnt_o, m_misses);
`endif
        finish_sim();
    end

endmodule
